// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the i2c_slave_mem register-file target.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK
  } state_e;

  // SCL hold length after a data-byte ACK or a read-byte load.
  localparam int unsigned STRETCH_CYCLES = 4;
  localparam int unsigned MEM_DEPTH_MAX  = 256;

  // Legal register-file depth: power of two, 2..MEM_DEPTH_MAX.
  function automatic bit mem_depth_ok(input int unsigned depth);
    return (depth >= 2) && (depth <= MEM_DEPTH_MAX) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// SCL/SDA synchronizers plus START, STOP and SCL edge decode.
module i2c_bus_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic scl_i,
  input  logic sda_i,
  input  logic hold_i,
  output logic sda_o,
  output logic start_c,
  output logic stop_c,
  output logic scl_rise_c,
  output logic scl_fall_c
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchronizer chains plus one delay flop; idle bus level is high.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      // While we hold SCL low ourselves, freeze the SCL history.
      if (!hold_i) begin
        scl_prev_q <= scl_s;
      end
      sda_prev_q <= sda_s;
    end
  end

  assign sda_o      = sda_s;
  assign start_c    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_c     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign scl_rise_c = ~hold_i & ~scl_prev_q & scl_s;
  assign scl_fall_c = ~hold_i & scl_prev_q & ~scl_s;

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C target with a byte register file: pointer write, data write with
// auto-increment, and sequential read.
// Optional clock stretching is enabled by defining I2C_SLAVE_STRETCH_EN.
module i2c_slave_mem
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned MEM_DEPTH   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int unsigned PTR_W = $clog2(MEM_DEPTH);

  if (!mem_depth_ok(MEM_DEPTH)) begin : g_depth_chk
    $error("i2c_slave_mem: MEM_DEPTH must be a power of 2 between 2 and 256");
  end

  state_e           state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [PTR_W-1:0] ptr_q;
  logic [7:0]       mem_q [MEM_DEPTH];
  logic             ack_ph_q;
  logic             rw_q;
  logic             sda_oe_q;
  logic             busy_q;
  logic             wr_strobe_q;
  logic [7:0]       wr_addr_q;
  logic [7:0]       wr_data_q;

  logic             sda_s;
  logic             start_c;
  logic             stop_c;
  logic             scl_rise_c;
  logic             scl_fall_c;
  logic             hold_c;
  logic [7:0]       rx_byte_c;
  logic [PTR_W-1:0] ptr_inc_c;
  logic             load_rd_c;

  i2c_bus_cond #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_cond (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .hold_i    (hold_c),
    .sda_o     (sda_s),
    .start_c   (start_c),
    .stop_c    (stop_c),
    .scl_rise_c(scl_rise_c),
    .scl_fall_c(scl_fall_c)
  );

  assign rx_byte_c = {shift_q[6:0], sda_s};
  assign ptr_inc_c = ptr_q + PTR_W'(1);
  // Fall that ends an ACK phase leading into a read byte.
  assign load_rd_c = scl_fall_c & ack_ph_q &
                     (((state_q == ADDR_ACK) & rw_q) | (state_q == RACK));

  // Protocol FSM, register file and registered bus/strobe outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      ack_ph_q    <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wr_strobe_q <= 1'b0;
      if (stop_c) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        ack_ph_q <= 1'b0;
      end else if (start_c) begin
        state_q   <= ADDR;
        bit_cnt_q <= 3'd0;
        sda_oe_q  <= 1'b0;
        ack_ph_q  <= 1'b0;
      end else if (load_rd_c) begin
        shift_q   <= mem_q[ptr_q];
        sda_oe_q  <= ~mem_q[ptr_q][7];
        ptr_q     <= ptr_inc_c;
        bit_cnt_q <= 3'd0;
        ack_ph_q  <= 1'b0;
        state_q   <= RDATA;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise_c) begin
              shift_q   <= rx_byte_c;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ack_ph_q <= 1'b0;
                if (rx_byte_c[7:1] == SLAVE_ADDR) begin
                  rw_q    <= rx_byte_c[0];
                  busy_q  <= 1'b1;
                  state_q <= ADDR_ACK;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                end
              end
            end
          end
          PTR: begin
            if (scl_rise_c) begin
              shift_q   <= rx_byte_c;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ptr_q    <= PTR_W'(rx_byte_c);
                ack_ph_q <= 1'b0;
                state_q  <= PTR_ACK;
              end
            end
          end
          WDATA: begin
            if (scl_rise_c) begin
              shift_q   <= rx_byte_c;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                mem_q[ptr_q] <= rx_byte_c;
                wr_strobe_q  <= 1'b1;
                wr_addr_q    <= 8'(ptr_q);
                wr_data_q    <= rx_byte_c;
                ptr_q        <= ptr_inc_c;
                ack_ph_q     <= 1'b0;
                state_q      <= WDATA_ACK;
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall_c) begin
              if (!ack_ph_q) begin
                sda_oe_q <= 1'b1;
                ack_ph_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                ack_ph_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
                state_q   <= (state_q == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
          RDATA: begin
            if (scl_fall_c) begin
              if (bit_cnt_q == 3'd7) begin
                sda_oe_q <= 1'b0;
                ack_ph_q <= 1'b0;
                state_q  <= RACK;
              end else begin
                shift_q   <= {shift_q[6:0], shift_q[7]};
                sda_oe_q  <= ~shift_q[6];
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          RACK: begin
            if (scl_rise_c) begin
              if (sda_s) begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                ack_ph_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef I2C_SLAVE_STRETCH_EN
  localparam int unsigned SC_W = $clog2(STRETCH_CYCLES);

  logic [SC_W-1:0] stretch_cnt_q;
  logic            scl_oe_q;
  logic            stretch_go_c;

  assign stretch_go_c = ~stop_c & ~start_c &
                        (load_rd_c | (scl_fall_c & ack_ph_q & (state_q == WDATA_ACK)));

  // Hold SCL low for STRETCH_CYCLES PCLK cycles from the triggering fall.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_oe_q      <= 1'b0;
      stretch_cnt_q <= '0;
    end else if (stretch_go_c) begin
      scl_oe_q      <= 1'b1;
      stretch_cnt_q <= SC_W'(STRETCH_CYCLES - 1);
    end else if (scl_oe_q) begin
      if (stretch_cnt_q == '0) begin
        scl_oe_q <= 1'b0;
      end else begin
        stretch_cnt_q <= stretch_cnt_q - SC_W'(1);
      end
    end
  end

  assign scl_oe = scl_oe_q;
  assign hold_c = scl_oe_q;
`else
  assign scl_oe = 1'b0;
  assign hold_c = 1'b0;
`endif

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Self-checking bench for i2c_slave_mem acting as a bit-banged I2C master.
`timescale 1ns/1ps
module tb_i2c_slave_mem;

  localparam int unsigned Q = 8;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       scl_bus;
  logic       sda_bus;
  logic       sda_oe;
  logic       scl_oe;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign scl_bus = scl_drv & ~scl_oe;
  assign sda_bus = sda_drv & ~sda_oe;

  i2c_slave_mem dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .scl_i    (scl_bus),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .scl_oe   (scl_oe),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_err = 0;

  // Monitors, sampled on the falling PCLK edge.
  logic [15:0] wr_log [256];
  int wr_cnt = 0;
  int sda_oe_cnt = 0;
  int scl_oe_cnt = 0;
  int stretch_run = 0;
  int stretch_runs = 0;
  int stretch_bad = 0;

  always @(negedge PCLK) begin
    if (wr_strobe && wr_cnt < 256) begin
      wr_log[wr_cnt] = {wr_addr, wr_data};
      wr_cnt = wr_cnt + 1;
    end
    if (sda_oe) sda_oe_cnt = sda_oe_cnt + 1;
    if (scl_oe) begin
      scl_oe_cnt  = scl_oe_cnt + 1;
      stretch_run = stretch_run + 1;
    end else if (stretch_run != 0) begin
      stretch_runs = stretch_runs + 1;
      if (stretch_run != 4) stretch_bad = stretch_bad + 1;
      stretch_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic hq();
    repeat (Q) @(negedge PCLK);
  endtask

  task automatic scl_high();
    scl_drv = 1'b1;
    for (int i = 0; i < 200 && scl_bus !== 1'b1; i++) @(negedge PCLK);
    if (scl_bus !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL scl_release: SCL still low after 200 cycles");
    end
    hq();
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; scl_drv = 1'b1; hq();
    sda_drv = 1'b0; hq();
    scl_drv = 1'b0; hq();
  endtask

  task automatic bus_rstart();
    sda_drv = 1'b1; hq();
    scl_high();
    sda_drv = 1'b0; hq();
    scl_drv = 1'b0; hq();
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; hq();
    scl_high();
    sda_drv = 1'b1; hq();
  endtask

  task automatic wbit(input logic b);
    sda_drv = b; hq();
    scl_high();
    scl_drv = 1'b0; hq();
  endtask

  task automatic rbit(output logic b);
    sda_drv = 1'b1; hq();
    scl_high();
    b = sda_bus;
    scl_drv = 1'b0; hq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic nb;
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(nb);
    ack = ~nb;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    logic bt;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rbit(bt);
      b = {b[6:0], bt};
    end
    wbit(~master_ack);
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] a0;
    logic [7:0] a1;
  } vec_t;

  initial begin
    vec_t       tbl [3];
    logic       ack;
    logic [7:0] rd;
    int         base;
    int         oe_base;

    tbl[0] = '{ptr: 8'h03, d0: 8'h5A, d1: 8'hC3, a0: 8'h03, a1: 8'h04};
    tbl[1] = '{ptr: 8'h0F, d0: 8'h11, d1: 8'h22, a0: 8'h0F, a1: 8'h00};
    tbl[2] = '{ptr: 8'h27, d0: 8'h80, d1: 8'h01, a0: 8'h07, a1: 8'h08};

    repeat (3) @(negedge PCLK);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_scl_oe", 32'(scl_oe), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    PRESETn = 1'b1;
    hq();

    // Write two bytes at a pointer, then read them back.
    for (int r = 0; r < 3; r++) begin
      base = wr_cnt;
      bus_start();
      write_byte(8'hA0, ack); check($sformatf("r%0d_wr_addr_ack", r), 32'(ack), 32'd1);
      check($sformatf("r%0d_busy_on", r), 32'(busy), 32'd1);
      write_byte(tbl[r].ptr, ack); check($sformatf("r%0d_ptr_ack", r), 32'(ack), 32'd1);
      write_byte(tbl[r].d0, ack);  check($sformatf("r%0d_d0_ack", r), 32'(ack), 32'd1);
      write_byte(tbl[r].d1, ack);  check($sformatf("r%0d_d1_ack", r), 32'(ack), 32'd1);
      bus_stop();
      check($sformatf("r%0d_busy_off", r), 32'(busy), 32'd0);
      check($sformatf("r%0d_strobes", r), 32'(wr_cnt - base), 32'd2);
      check($sformatf("r%0d_wr0", r), 32'(wr_log[base]), 32'({tbl[r].a0, tbl[r].d0}));
      check($sformatf("r%0d_wr1", r), 32'(wr_log[base + 1]), 32'({tbl[r].a1, tbl[r].d1}));

      bus_start();
      write_byte(8'hA0, ack); check($sformatf("r%0d_rd_addr_ack", r), 32'(ack), 32'd1);
      write_byte(tbl[r].ptr, ack); check($sformatf("r%0d_rd_ptr_ack", r), 32'(ack), 32'd1);
      bus_rstart();
      write_byte(8'hA1, ack); check($sformatf("r%0d_rd_a1_ack", r), 32'(ack), 32'd1);
      read_byte(1'b1, rd); check($sformatf("r%0d_rd0", r), 32'(rd), 32'(tbl[r].d0));
      read_byte(1'b0, rd); check($sformatf("r%0d_rd1", r), 32'(rd), 32'(tbl[r].d1));
      check($sformatf("r%0d_nack_sda_rel", r), 32'(sda_oe), 32'd0);
      check($sformatf("r%0d_nack_busy", r), 32'(busy), 32'd0);
      bus_stop();
    end

    // Pointer wrap: location 0 holds the byte written after 0x0F.
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h00, ack);
    bus_rstart();
    write_byte(8'hA1, ack); check("wrap_a1_ack", 32'(ack), 32'd1);
    read_byte(1'b0, rd); check("wrap_rd_ptr0", 32'(rd), 32'h22);
    bus_stop();

    // Wrong address: no ACK, no drive, no write.
    base = wr_cnt;
    oe_base = sda_oe_cnt;
    bus_start();
    write_byte(8'hA2, ack); check("wrong_addr_ack", 32'(ack), 32'd0);
    check("wrong_addr_busy", 32'(busy), 32'd0);
    write_byte(8'h55, ack); check("wrong_data_ack", 32'(ack), 32'd0);
    bus_stop();
    check("wrong_sda_oe_cycles", 32'(sda_oe_cnt - oe_base), 32'd0);
    check("wrong_strobes", 32'(wr_cnt - base), 32'd0);

    // Reset while the target drives SDA during a read.
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h03, ack);
    bus_rstart();
    write_byte(8'hA1, ack);
    check("rstrd_sda_driven", 32'(sda_oe), 32'd1);
    PRESETn = 1'b0;
    #1;
    check("rstrd_sda_rel", 32'(sda_oe), 32'd0);
    check("rstrd_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    bus_stop();
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h03, ack);
    bus_rstart();
    write_byte(8'hA1, ack); check("rstrd_a1_ack", 32'(ack), 32'd1);
    read_byte(1'b0, rd); check("rstrd_mem_cleared", 32'(rd), 32'h00);
    bus_stop();
    hq();

`ifdef I2C_SLAVE_STRETCH_EN
    check("stretch_len_bad", 32'(stretch_bad), 32'd0);
    check("stretch_seen", 32'(stretch_runs >= 6), 32'd1);
`else
    check("scl_oe_cycles", 32'(scl_oe_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
